// File: rtl/vote_session_ctrl_pkg.sv
// Shared types and width helpers for the voting-session blocks.
package vote_session_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Bit width needed to index n values, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Session request, per-voter vote lanes and result handshake of one voting session.
interface vote_session_ctrl_if
  import vote_session_ctrl_pkg::*;
#(
  parameter int N = 5
);
  localparam int CW = width_of(N + 1);

  logic          start;
  logic [N-1:0]  vote_valid;
  logic [N-1:0]  vote_yes;
  logic          result_ack;
  logic          busy;
  logic [N-1:0]  voted;
  logic [CW-1:0] yes_count;
  logic          result_valid;
  logic          result;
  logic          timed_out;

  modport master (
    output start, vote_valid, vote_yes, result_ack,
    input  busy, voted, yes_count, result_valid, result, timed_out
  );

  modport slave (
    input  start, vote_valid, vote_yes, result_ack,
    output busy, voted, yes_count, result_valid, result, timed_out
  );
endinterface

// File: rtl/vote_session_ctrl_popcount.sv
// Combinational count of set bits in an N-bit vector.
module vote_popcount
  import vote_session_ctrl_pkg::*;
#(
  parameter  int N  = 5,
  localparam int CW = width_of(N + 1)
) (
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] count
);

  // NOTE: blocking '=' is correct here; each loop pass must see the previous partial sum.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// One majority-vote session: collect at most one vote per voter, decide early or on timeout,
// then hold the result until the consumer acknowledges it.
module vote_session_ctrl
  import vote_session_ctrl_pkg::*;
#(
  parameter  int N       = 5,
  parameter  int TIMEOUT = 16,
  localparam int CW      = width_of(N + 1),
  localparam int TW      = width_of(TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst,
  vote_session_ctrl_if.slave bus
);

  state_t        state, state_d;
  logic [N-1:0]  voted_q, voted_d;
  logic [CW-1:0] yes_q, yes_d, no_q, no_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          result_q, result_d;
  logic          timed_out_q, timed_out_d;

  logic [N-1:0]  accept;
  logic [CW-1:0] yes_add, no_add, yes_next, no_next;

  // A voter counts only once per session and only while collecting.
  assign accept   = (state == ST_COLLECT) ? (bus.vote_valid & ~voted_q) : '0;
  assign yes_next = yes_q + yes_add;
  assign no_next  = no_q + no_add;

  vote_popcount #(.N(N)) u_yes_pop (.vec(accept & bus.vote_yes),  .count(yes_add));
  vote_popcount #(.N(N)) u_no_pop  (.vec(accept & ~bus.vote_yes), .count(no_add));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state;
    voted_d     = voted_q;
    yes_d       = yes_q;
    no_d        = no_q;
    timer_d     = timer_q;
    result_d    = result_q;
    timed_out_d = timed_out_q;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_COLLECT;
          voted_d     = '0;
          yes_d       = '0;
          no_d        = '0;
          result_d    = 1'b0;
          timed_out_d = 1'b0;
          timer_d     = TW'(TIMEOUT - 1);
        end
      end
      ST_COLLECT: begin
        voted_d = voted_q | accept;
        yes_d   = yes_next;
        no_d    = no_next;
        // A decisive count beats the timer on its last cycle.
        if (yes_next > CW'(N / 2)) begin
          state_d  = ST_DONE;
          result_d = 1'b1;
        end else if (no_next >= CW'(N - N / 2)) begin
          state_d  = ST_DONE;
          result_d = 1'b0;
        end else if (timer_q == '0) begin
          state_d     = ST_DONE;
          result_d    = 1'b0;
          timed_out_d = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_DONE: begin
        if (bus.result_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      voted_q     <= '0;
      yes_q       <= '0;
      no_q        <= '0;
      timer_q     <= '0;
      result_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state       <= state_d;
      voted_q     <= voted_d;
      yes_q       <= yes_d;
      no_q        <= no_d;
      timer_q     <= timer_d;
      result_q    <= result_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign bus.busy         = (state != ST_IDLE);
  assign bus.result_valid = (state == ST_DONE);
  assign bus.voted        = voted_q;
  assign bus.yes_count    = yes_q;
  assign bus.result       = result_q;
  assign bus.timed_out    = timed_out_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl: N=5 and N=4 instances, TIMEOUT=8.
module tb_vote_session_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vote_session_ctrl_if #(.N(5)) bus5 ();
  vote_session_ctrl_if #(.N(4)) bus4 ();

  vote_session_ctrl #(.N(5), .TIMEOUT(8)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));
  vote_session_ctrl #(.N(4), .TIMEOUT(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vote5(input logic [4:0] v, input logic [4:0] y);
    bus5.vote_valid = v;
    bus5.vote_yes   = y;
    step();
    bus5.vote_valid = '0;
    bus5.vote_yes   = '0;
  endtask

  task automatic start5();
    bus5.start = 1'b1;
    step();
    bus5.start = 1'b0;
  endtask

  task automatic ack5();
    bus5.result_ack = 1'b1;
    step();
    bus5.result_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus5.start = 0; bus5.vote_valid = '0; bus5.vote_yes = '0; bus5.result_ack = 0;
    bus4.start = 0; bus4.vote_valid = '0; bus4.vote_yes = '0; bus4.result_ack = 0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_busy",   32'(bus5.busy), 0);
    check("rst_valid",  32'(bus5.result_valid), 0);
    check("rst_voted",  32'(bus5.voted), 0);
    check("rst_yes",    32'(bus5.yes_count), 0);
    check("rst_result", 32'(bus5.result), 0);
    check("rst_to",     32'(bus5.timed_out), 0);
    rst = 1'b0;
    step();

    // Everyone votes in the first COLLECT cycle: 3 yes of 5.
    start5();
    check("t1_busy", 32'(bus5.busy), 1);
    check("t1_valid_pre", 32'(bus5.result_valid), 0);
    vote5(5'b11111, 5'b00111);
    check("t1_valid",  32'(bus5.result_valid), 1);
    check("t1_result", 32'(bus5.result), 1);
    check("t1_yes",    32'(bus5.yes_count), 3);
    check("t1_to",     32'(bus5.timed_out), 0);
    check("t1_voted",  32'(bus5.voted), 32'h1f);
    vote5(5'b11111, 5'b00000);
    check("t1_done_ignores_votes", 32'(bus5.yes_count), 3);
    ack5();
    check("t1_ack_valid",  32'(bus5.result_valid), 0);
    check("t1_ack_busy",   32'(bus5.busy), 0);
    check("t1_hold_result", 32'(bus5.result), 1);

    // Serial votes yes,no,yes,no,yes with a duplicate from voter 0.
    start5();
    check("t2_cleared_yes", 32'(bus5.yes_count), 0);
    check("t2_cleared_voted", 32'(bus5.voted), 0);
    vote5(5'b00001, 5'b00001);
    vote5(5'b00010, 5'b00000);
    check("t2_yes_a",   32'(bus5.yes_count), 1);
    check("t2_voted_a", 32'(bus5.voted), 32'h03);
    vote5(5'b00001, 5'b00000);
    check("t2_dup_yes",   32'(bus5.yes_count), 1);
    check("t2_dup_voted", 32'(bus5.voted), 32'h03);
    check("t2_dup_valid", 32'(bus5.result_valid), 0);
    vote5(5'b00100, 5'b00100);
    vote5(5'b01000, 5'b00000);
    check("t2_2v2_valid", 32'(bus5.result_valid), 0);
    vote5(5'b10000, 5'b10000);
    check("t2_valid",  32'(bus5.result_valid), 1);
    check("t2_result", 32'(bus5.result), 1);
    check("t2_yes",    32'(bus5.yes_count), 3);
    ack5();

    // Three no-votes settle it early.
    start5();
    vote5(5'b00111, 5'b00000);
    check("t3_valid",  32'(bus5.result_valid), 1);
    check("t3_result", 32'(bus5.result), 0);
    check("t3_yes",    32'(bus5.yes_count), 0);
    check("t3_to",     32'(bus5.timed_out), 0);
    check("t3_voted",  32'(bus5.voted), 32'h07);
    ack5();

    // Two yes votes only: timer expires after the 8th COLLECT cycle.
    start5();
    vote5(5'b00011, 5'b00011);
    repeat (6) step();
    check("t4_valid_7th", 32'(bus5.result_valid), 0);
    step();
    check("t4_valid",  32'(bus5.result_valid), 1);
    check("t4_result", 32'(bus5.result), 0);
    check("t4_to",     32'(bus5.timed_out), 1);
    check("t4_yes",    32'(bus5.yes_count), 2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_valid", 32'(bus5.result_valid), 1);
      check("t4_hold_to",    32'(bus5.timed_out), 1);
      check("t4_hold_yes",   32'(bus5.yes_count), 2);
      check("t4_hold_voted", 32'(bus5.voted), 32'h03);
    end
    ack5();
    check("t4_ack_valid", 32'(bus5.result_valid), 0);
    check("t4_ack_to",    32'(bus5.timed_out), 1);

    // N=4 tie, then start presented together with ack.
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    bus4.vote_valid = 4'b1111;
    bus4.vote_yes   = 4'b0011;
    step();
    bus4.vote_valid = '0;
    bus4.vote_yes   = '0;
    check("t5_valid",  32'(bus4.result_valid), 1);
    check("t5_result", 32'(bus4.result), 0);
    check("t5_to",     32'(bus4.timed_out), 0);
    check("t5_yes",    32'(bus4.yes_count), 2);
    bus4.start = 1'b1;
    bus4.result_ack = 1'b1;
    step();
    bus4.start = 1'b0;
    bus4.result_ack = 1'b0;
    check("t5_ack_busy", 32'(bus4.busy), 0);
    step();
    check("t5_no_restart", 32'(bus4.busy), 0);

    // Reset mid-COLLECT, then a clean session.
    start5();
    vote5(5'b00011, 5'b00001);
    check("t6_voted_pre", 32'(bus5.voted), 32'h03);
    check("t6_yes_pre",   32'(bus5.yes_count), 1);
    rst = 1'b1;
    #1;
    check("t6_busy",  32'(bus5.busy), 0);
    check("t6_voted", 32'(bus5.voted), 0);
    check("t6_yes",   32'(bus5.yes_count), 0);
    check("t6_valid", 32'(bus5.result_valid), 0);
    check("t6_result", 32'(bus5.result), 0);
    check("t6_to",    32'(bus5.timed_out), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    start5();
    check("t6_new_busy",  32'(bus5.busy), 1);
    check("t6_new_voted", 32'(bus5.voted), 0);
    vote5(5'b11100, 5'b11100);
    check("t6_new_result", 32'(bus5.result), 1);
    check("t6_new_voted2", 32'(bus5.voted), 32'h1c);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
